uart_line_buffer: RTL and testbench

- Line-editing buffer between the UART receiver (uart_rx_8n1) and the UART transmitter (uart_tx_8n1), on the baud-rate clock.
- Collects received bytes into a line, supporting backspace editing.
- On carriage return, replays the stored line to the transmitter one byte at a time, followed by CR LF.
- Replaces direct byte-for-byte echo with line-at-a-time echo.

---
 rtl/uart_line_buffer.sv | 161 ++++++++++++++++
 tb/tb_uart_line_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_line_buffer.sv
// uart_line_buffer: line-editing buffer between the UART receiver and transmitter.
// Collects received bytes into a line (backspace/delete remove the last byte). A carriage
// return replays the stored line to the transmitter one byte at a time, followed by CR LF.
//
// Ports:
//   clk       baud-rate clock shared with the rx/tx modules
//   reset     synchronous active-high reset
//   rx_byte   received byte, valid with rx_done
//   rx_done   one-cycle strobe from the receiver
//   tx_byte   byte to transmit, held stable until the transmitter reports done
//   tx_send   one-cycle strobe starting a transmit of tx_byte
//   tx_done   one-cycle strobe from the transmitter
//   busy      high while replaying a line
//   count     bytes currently stored (0..DEPTH)
//   overflow  sticky flag: a byte was dropped because the buffer was full
//   rx_drop   one-cycle strobe: a received byte was discarded while busy
module uart_line_buffer #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_done,
  output logic [7:0]        tx_byte,
  output logic              tx_send,
  input  logic              tx_done,
  output logic              busy,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              rx_drop
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DepthC = CntW'(DEPTH);

  typedef enum logic [2:0] {
    StFill, StLoad, StWait, StCr, StCrWait, StLf, StLfWait
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W-1:0]   rd_q, rd_d;
  logic                ovf_q, ovf_d;
  logic [7:0]          tx_byte_q, tx_byte_d;
  logic                tx_send_q, tx_send_d;
  logic                busy_q, busy_d;
  logic                rx_drop_q, rx_drop_d;

  logic [7:0]          mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;

  // A tx_done arriving while our own tx_send is still high belongs to no byte we sent.
  logic                done_ok;
  assign done_ok = tx_done && !tx_send_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rd_d      = rd_q;
    ovf_d     = ovf_q;
    tx_byte_d = tx_byte_q;
    tx_send_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = count_q[ADDR_W-1:0];

    unique case (state_q)
      StFill: begin
        if (rx_done) begin
          if (rx_byte == 8'h0D) begin
            rd_d    = '0;
            state_d = (count_q != '0) ? StLoad : StCr;
          end else if (rx_byte == 8'h08 || rx_byte == 8'h7F) begin
            if (count_q != '0) count_d = count_q - CntW'(1);
          end else if (count_q < DepthC) begin
            mem_we  = 1'b1;
            count_d = count_q + CntW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      StLoad: begin
        tx_byte_d = mem_q[rd_q];
        tx_send_d = 1'b1;
        state_d   = StWait;
      end
      StWait: begin
        if (done_ok) begin
          if ({1'b0, rd_q} == count_q - CntW'(1)) begin
            state_d = StCr;
          end else begin
            rd_d    = rd_q + ADDR_W'(1);
            state_d = StLoad;
          end
        end
      end
      StCr: begin
        tx_byte_d = 8'h0D;
        tx_send_d = 1'b1;
        state_d   = StCrWait;
      end
      StCrWait: begin
        if (done_ok) state_d = StLf;
      end
      StLf: begin
        tx_byte_d = 8'h0A;
        tx_send_d = 1'b1;
        state_d   = StLfWait;
      end
      StLfWait: begin
        if (done_ok) begin
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase

    rx_drop_d = rx_done && (state_q != StFill);
    // Registered from the next state so busy lines up with the state register.
    busy_d    = (state_d != StFill);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFill;
      count_q   <= '0;
      rd_q      <= '0;
      ovf_q     <= 1'b0;
      tx_byte_q <= 8'h00;
      tx_send_q <= 1'b0;
      busy_q    <= 1'b0;
      rx_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_q      <= rd_d;
      ovf_q     <= ovf_d;
      tx_byte_q <= tx_byte_d;
      tx_send_q <= tx_send_d;
      busy_q    <= busy_d;
      rx_drop_q <= rx_drop_d;
    end
  end

  // Line storage needs no reset; only the first count entries are ever read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= rx_byte;
  end

  assign tx_byte  = tx_byte_q;
  assign tx_send  = tx_send_q;
  assign busy     = busy_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign rx_drop  = rx_drop_q;

endmodule

// File: tb/tb_uart_line_buffer.sv
// Self-checking bench for uart_line_buffer: directed lines plus random lines, each checked
// against a queue-based model of the line and of the expected transmit sequence.
module tb_uart_line_buffer;

  localparam int unsigned Depth = 32;
  localparam int unsigned AddrW = 5;

  logic             clk;
  logic             reset;
  logic [7:0]       rx_byte;
  logic             rx_done;
  logic [7:0]       tx_byte;
  logic             tx_send;
  logic             tx_done;
  logic             busy;
  logic [AddrW:0]   count;
  logic             overflow;
  logic             rx_drop;

  uart_line_buffer #(
    .DEPTH  (Depth),
    .ADDR_W (AddrW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_byte  (rx_byte),
    .rx_done  (rx_done),
    .tx_byte  (tx_byte),
    .tx_send  (tx_send),
    .tx_done  (tx_done),
    .busy     (busy),
    .count    (count),
    .overflow (overflow),
    .rx_drop  (rx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Model: the bytes the line should hold, the overflow flag, and the expected replay.
  logic [7:0] line_q[$];
  logic [7:0] exp_q[$];
  bit         ovf_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx(input logic [7:0] b);
    rx_byte = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Service the transmitter for every expected byte; optionally raise tx_done during the
  // tx_send cycle (must be ignored) and inject a received byte during the wait.
  task automatic replay(input bit coinc, input bit inject);
    logic [7:0] held;
    int d;
    for (int i = 0; i < exp_q.size(); i++) begin
      tick();
      check_eq("send_lat", {31'd0, tx_send}, 32'd1);
      check_eq("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q[i]});
      check_eq("busy_replay", {31'd0, busy}, 32'd1);
      held = exp_q[i];
      if (coinc) tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check_eq("send_pulse", {31'd0, tx_send}, 32'd0);
      d = $urandom_range(2, 20);
      for (int j = 0; j < d; j++) begin
        if (inject && j == 0) begin
          rx_byte = 8'h55;
          rx_done = 1'b1;
        end
        tick();
        rx_done = 1'b0;
        check_eq("rx_drop", {31'd0, rx_drop}, (inject && j == 0) ? 32'd1 : 32'd0);
        check_eq("hold_send", {31'd0, tx_send}, 32'd0);
        check_eq("hold_byte", {24'd0, tx_byte}, {24'd0, held});
        check_eq("hold_count", {26'd0, count}, line_q.size());
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
    end
    check_eq("end_busy", {31'd0, busy}, 32'd0);
    check_eq("end_count", {26'd0, count}, 32'd0);
    check_eq("end_ovf", {31'd0, overflow}, 32'd0);
  endtask

  task automatic put(input logic [7:0] b, input bit coinc, input bit inject);
    rx(b);
    if (b == 8'h0D) begin
      exp_q = line_q;
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      replay(coinc, inject);
      line_q.delete();
      ovf_m = 1'b0;
    end else begin
      if (b == 8'h08 || b == 8'h7F) begin
        if (line_q.size() > 0) void'(line_q.pop_back());
      end else if (line_q.size() < Depth) begin
        line_q.push_back(b);
      end else begin
        ovf_m = 1'b1;
      end
      check_eq("fill_count", {26'd0, count}, line_q.size());
      check_eq("fill_ovf", {31'd0, overflow}, {31'd0, ovf_m});
      check_eq("fill_busy", {31'd0, busy}, 32'd0);
      check_eq("fill_send", {31'd0, tx_send}, 32'd0);
      check_eq("fill_drop", {31'd0, rx_drop}, 32'd0);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    if ($urandom_range(0, 99) < 12) return ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
    do b = 8'($urandom_range(0, 255)); while (b == 8'h08 || b == 8'h0D || b == 8'h7F);
    return b;
  endfunction

  initial begin
    reset   = 1'b1;
    rx_byte = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    ovf_m   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_count", {26'd0, count}, 32'd0);
    check_eq("rst_send", {31'd0, tx_send}, 32'd0);
    check_eq("rst_byte", {24'd0, tx_byte}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    check_eq("rst_drop", {31'd0, rx_drop}, 32'd0);

    // "AB" CR
    put(8'h41, 0, 0); put(8'h42, 0, 0); put(8'h0D, 0, 0);
    // "ABC" BS "D" CR
    put(8'h41, 0, 0); put(8'h42, 0, 0); put(8'h43, 0, 0); put(8'h08, 0, 0);
    put(8'h44, 0, 0); put(8'h0D, 0, 0);
    // Backspace on empty line, then empty line
    put(8'h08, 0, 0); put(8'h7F, 0, 0);
    check_eq("bs_empty", {26'd0, count}, 32'd0);
    put(8'h0D, 0, 0);
    // Overflow: 35 bytes into a 32-byte line
    for (int i = 0; i < 35; i++) put(8'(8'h30 + i), 0, 0);
    check_eq("sat_count", {26'd0, count}, 32'd32);
    check_eq("sat_ovf", {31'd0, overflow}, 32'd1);
    put(8'h0D, 0, 0);
    // Byte received during replay, and tx_done coincident with tx_send
    put(8'h31, 0, 0); put(8'h32, 0, 0); put(8'h0D, 1, 1);

    // Reset while waiting mid-line
    put(8'h41, 0, 0); put(8'h42, 0, 0);
    rx(8'h0D);
    tick();
    check_eq("mid_send", {31'd0, tx_send}, 32'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    line_q.delete();
    ovf_m = 1'b0;
    check_eq("mid_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_count", {26'd0, count}, 32'd0);
    check_eq("mid_send0", {31'd0, tx_send}, 32'd0);
    check_eq("mid_byte", {24'd0, tx_byte}, 32'd0);
    check_eq("mid_ovf", {31'd0, overflow}, 32'd0);
    put(8'h5A, 0, 0); put(8'h0D, 0, 0);

    // Random lines
    for (int l = 0; l < 12; l++) begin
      int n;
      n = $urandom_range(0, 40);
      for (int k = 0; k < n; k++) put(rand_byte(), 0, 0);
      put(8'h0D, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
